// File: rtl/avalon_pkg.sv
// avalon_pkg: shared stream width, 4/5/6 sequence bounds and checker state encoding
package avalon_pkg;
  localparam int DEF_DATA_W = 8;
  localparam logic [7:0] SEQ_FIRST = 8'h04;
  localparam logic [7:0] SEQ_LAST = 8'h06;
  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} chk_state_e;
endpackage

// File: rtl/avalon_st_fifo.sv
// avalon_st_fifo: power-of-two circular buffer with registered occupancy count
module avalon_st_fifo #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q, count_d;
  logic push_ok, pop_ok;
  assign full = count_q == (AW+1)'(FIFO_DEPTH);
  assign empty = count_q == '0;
  assign push_ok = push & ~full;
  assign pop_ok = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q];
  // occupancy follows push/pop; simultaneous push and pop leave it unchanged
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + (AW+1)'(1);
    else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
  end
  // pointers wrap naturally since the depth is a power of two
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end
  // storage needs no reset: an empty buffer never exposes stale entries
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/avalon_st_seq_sink.sv
// avalon_st_seq_sink: buffered Avalon-ST sink with throttled drain and sequence checker
module avalon_st_seq_sink
  import avalon_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] FIRST_VAL = DATA_W'(SEQ_FIRST),
  parameter logic [DATA_W-1:0] LAST_VAL = DATA_W'(SEQ_LAST),
  parameter int STALL_PERIOD = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain_en,
  input  logic              err_clr,
  output logic [15:0]       beat_count,
  output logic [15:0]       err_count,
  output logic              err_flag,
  output logic              locked,
  output logic [DATA_W-1:0] last_data
);
  localparam int TW = $clog2(STALL_PERIOD + 2);
  logic rdy_en_q, full, empty, push, pop;
  logic [DATA_W-1:0] rd_data;
  logic [TW-1:0] throttle_q, throttle_d;
  chk_state_e state_q, state_d;
  logic [DATA_W-1:0] exp_q, exp_d, last_q, last_d;
  logic [15:0] beat_q, beat_d, err_cnt_q, err_cnt_d;
  logic err_flag_q, err_flag_d;
  function automatic logic [DATA_W-1:0] nxt(input logic [DATA_W-1:0] v);
    return v == LAST_VAL ? FIRST_VAL : v + DATA_W'(1);
  endfunction
  assign in_ready = rdy_en_q & ~full;
  assign push = in_valid & in_ready;
  assign pop = drain_en & ~empty & (throttle_q == '0);
  assign beat_count = beat_q;
  assign err_count = err_cnt_q;
  assign err_flag = err_flag_q;
  assign locked = state_q == LOCKED;
  assign last_data = last_q;
  avalon_st_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .resetn(resetn), .push(push), .pop(pop), .wr_data(in_data),
    .rd_data(rd_data), .full(full), .empty(empty)
  );
  // throttle and checker next state: match advances, mismatch counts and relocks on FIRST_VAL
  always_comb begin
    throttle_d = throttle_q == TW'(STALL_PERIOD) ? '0 : throttle_q + TW'(1);
    state_d = state_q;
    exp_d = exp_q;
    last_d = last_q;
    beat_d = beat_q;
    err_cnt_d = err_clr ? '0 : err_cnt_q;
    err_flag_d = err_flag_q & ~err_clr;
    if (pop) begin
      last_d = rd_data;
      beat_d = beat_q == 16'hFFFF ? beat_q : beat_q + 16'd1;
      if (state_q == LOCKED && rd_data == exp_q) exp_d = nxt(exp_q);
      else if (rd_data == FIRST_VAL) begin
        state_d = LOCKED;
        exp_d = nxt(FIRST_VAL);
      end else state_d = HUNT;
      if (state_q == LOCKED && rd_data != exp_q) begin
        err_cnt_d = err_clr ? 16'd1 : (err_cnt_q == 16'hFFFF ? err_cnt_q : err_cnt_q + 16'd1);
        err_flag_d = 1'b1;
      end
    end
  end
  // state registers; rdy_en_q holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdy_en_q <= 1'b0;
      throttle_q <= '0;
      state_q <= HUNT;
      exp_q <= FIRST_VAL;
      last_q <= '0;
      beat_q <= '0;
      err_cnt_q <= '0;
      err_flag_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      throttle_q <= throttle_d;
      state_q <= state_d;
      exp_q <= exp_d;
      last_q <= last_d;
      beat_q <= beat_d;
      err_cnt_q <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end
endmodule

// File: tb/tb_avalon_st_seq_sink.sv
// tb_avalon_st_seq_sink: directed checks of handshake, throttle, checker and counters
module tb_avalon_st_seq_sink;
  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  logic v0, rdy0, dr0, clr0, ef0, lk0;
  logic [7:0] d0, ld0;
  logic [15:0] bc0, ec0;
  logic v2, rdy2, dr2, clr2, ef2, lk2;
  logic [7:0] d2, ld2;
  logic [15:0] bc2, ec2;
  int c1, c2, c3, c4, c5, c6;

  avalon_st_seq_sink dut0 (
    .clk(clk), .resetn(resetn), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
    .drain_en(dr0), .err_clr(clr0), .beat_count(bc0), .err_count(ec0),
    .err_flag(ef0), .locked(lk0), .last_data(ld0)
  );
  avalon_st_seq_sink #(.STALL_PERIOD(2)) dut2 (
    .clk(clk), .resetn(resetn), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
    .drain_en(dr2), .err_clr(clr2), .beat_count(bc2), .err_count(ec2),
    .err_flag(ef2), .locked(lk2), .last_data(ld2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    {v0, d0, dr0, clr0} = '0;
    {v2, d2, dr2, clr2} = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", rdy0, 0);
    chk("rst_beats", bc0, 0);
    chk("rst_errs", ec0 | 16'(ef0), 0);
    chk("rst_locked", lk0, 0);
    chk("rst_last", ld0, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic push0(input logic [7:0] d);
    int n = 0;
    v0 = 1'b1;
    d0 = d;
    while (!rdy0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push0_accept", n < 50, 1);
    @(negedge clk);
  endtask

  task automatic push2(input logic [7:0] d);
    int n = 0;
    v2 = 1'b1;
    d2 = d;
    while (!rdy2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push2_accept", n < 50, 1);
    @(negedge clk);
  endtask

  task automatic wait_bc2(input int n, output int c);
    int k = 0;
    while (bc2 != 16'(n) && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("bc2_reach", k < 30, 1);
    c = cyc;
  endtask

  initial begin
    do_reset();
    chk("ready_after_release", rdy0, 1);
    dr0 = 1'b1;
    push0(8'h04);
    push0(8'h05);
    chk("t1_locked_first_pop", lk0, 1);
    chk("t1_beats_first_pop", bc0, 1);
    chk("t1_last_first_pop", ld0, 8'h04);
    push0(8'h06); push0(8'h04); push0(8'h05); push0(8'h06);
    v0 = 1'b0; d0 = '0;
    repeat (3) @(negedge clk);
    chk("t1_beats", bc0, 6);
    chk("t1_errs", ec0, 0);
    chk("t1_last", ld0, 8'h06);
    chk("t1_locked", lk0, 1);

    do_reset();
    dr0 = 1'b1;
    push0(8'h00); push0(8'h00); push0(8'h05); push0(8'h04);
    chk("t2_hunt_locked", lk0, 0);
    chk("t2_hunt_beats", bc0, 3);
    chk("t2_hunt_errs", ec0, 0);
    push0(8'h05);
    chk("t2_lock_4th", lk0, 1);
    push0(8'h06);
    v0 = 1'b0; d0 = '0;
    repeat (3) @(negedge clk);
    chk("t2_beats", bc0, 6);
    chk("t2_errs", ec0, 0);

    do_reset();
    push0(8'h04); push0(8'h05); push0(8'h06); push0(8'h04);
    v0 = 1'b1; d0 = 8'h05;
    chk("t3_full_ready", rdy0, 0);
    repeat (3) @(negedge clk);
    chk("t3_full_ready_hold", rdy0, 0);
    chk("t3_no_drain", bc0, 0);
    dr0 = 1'b1;
    @(negedge clk);
    chk("t3_ready_after_pop", rdy0, 1);
    chk("t3_one_pop", bc0, 1);
    push0(8'h05); push0(8'h06);
    v0 = 1'b0; d0 = '0;
    repeat (8) @(negedge clk);
    chk("t3_beats", bc0, 6);
    chk("t3_errs", ec0, 0);
    chk("t3_last", ld0, 8'h06);
    chk("t3_locked", lk0, 1);

    do_reset();
    dr0 = 1'b1;
    push0(8'h04); push0(8'h05); push0(8'h05); push0(8'h06);
    chk("t4_err_count", ec0, 1);
    chk("t4_err_flag", ef0, 1);
    chk("t4_hunt", lk0, 0);
    push0(8'h04);
    chk("t4_hunt_on_6", lk0, 0);
    v0 = 1'b0; d0 = '0;
    @(negedge clk);
    chk("t4_relock", lk0, 1);
    chk("t4_err_once", ec0, 1);
    chk("t4_beats", bc0, 5);

    do_reset();
    dr0 = 1'b1;
    push0(8'h04); push0(8'h05); push0(8'h04);
    chk("t5_locked_pre", lk0, 1);
    v0 = 1'b0; d0 = '0;
    @(negedge clk);
    chk("t5_locked_stays", lk0, 1);
    chk("t5_err_count", ec0, 1);
    chk("t5_err_flag", ef0, 1);
    chk("t5_beats", bc0, 3);

    do_reset();
    push2(8'h04); push2(8'h05); push2(8'h06); push2(8'h04);
    v2 = 1'b1; d2 = 8'h05;
    chk("t6_full_ready", rdy2, 0);
    v2 = 1'b0; d2 = '0;
    dr2 = 1'b1;
    wait_bc2(1, c1);
    wait_bc2(2, c2);
    wait_bc2(3, c3);
    wait_bc2(4, c4);
    chk("t6_gap12", c2 - c1, 3);
    chk("t6_gap23", c3 - c2, 3);
    chk("t6_gap34", c4 - c3, 3);
    chk("t6_locked", lk2, 1);
    chk("t6_errs", ec2, 0);
    dr2 = 1'b0;
    push2(8'h06); push2(8'h04); push2(8'h06);
    v2 = 1'b0; d2 = '0;
    dr2 = 1'b1;
    wait_bc2(5, c5);
    wait_bc2(6, c6);
    dr2 = 1'b0;
    chk("t6_pre_err", ec2, 1);
    chk("t6_pre_locked", lk2, 1);
    while (((cyc + 1 - c6) % 3) != 0) @(negedge clk);
    dr2 = 1'b1; clr2 = 1'b1;
    @(negedge clk);
    dr2 = 1'b0; clr2 = 1'b0;
    chk("t6_err_wins_count", ec2, 1);
    chk("t6_err_wins_flag", ef2, 1);
    chk("t6_beats", bc2, 7);
    chk("t6_hunt", lk2, 0);
    chk("t6_last", ld2, 8'h06);
    clr2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b0;
    chk("t6_clr_count", ec2, 0);
    chk("t6_clr_flag", ef2, 0);

    do_reset();
    dr0 = 1'b1;
    push0(8'h04); push0(8'h05); push0(8'h06);
    v0 = 1'b1; d0 = 8'h04;
    #2 resetn = 1'b0;
    #1;
    chk("t7_async_ready", rdy0, 0);
    chk("t7_async_beats", bc0, 0);
    chk("t7_async_locked", lk0, 0);
    chk("t7_async_last", ld0, 0);
    v0 = 1'b0; d0 = '0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("t7_empty_after", bc0, 0);
    chk("t7_ready_after", rdy0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
